dps_decoder_27: RTL

- Receive-side counterpart of the 27-wire DPS Fibonacci-numeral-system CAC encoder.
- Takes a registered 27-bit codeword off the bus and reconstructs the `DBLEN27`-bit data word as the weighted sum of the set code bits.
- Three-stage pipeline with valid/ready handshake and back-pressure.
- Sits at the far end of the CAC-encoded link, feeding the sink datapath.

---
 rtl/dps_decoder_27_pkg.sv | 44 ++++
 rtl/dps_decoder_27_group_sum.sv | 40 ++++
 rtl/dps_decoder_27.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dps_decoder_27_pkg.sv
// ============================================================================
//  Module   : dps_decoder_27_pkg
//  Brief    : Shared constants and Fibonacci weight helpers for the DPS-27 decoder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dps_decoder_27_pkg;

  localparam int unsigned DBLEN27       = 19;
  localparam int unsigned DPS27_ACCW    = DBLEN27 + 2;
  localparam int unsigned DPS27_GROUPS  = 3;
  localparam int unsigned DPS27_GROUP_W = 9;

  // Fibonacci numeral n with FNS1 = FNS2 = 1.
  function automatic int unsigned fns(input int unsigned n);
    int unsigned a;
    int unsigned b;
    int unsigned t;
    a = 1;
    b = 1;
    for (int unsigned i = 3; i <= n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  // Bit 25 carries a doubled weight; that is what makes the DPS variant dense.
  function automatic int unsigned dps27_weight(input int unsigned k);
    if (k == 0)
      return 1;
    else if (k <= 24)
      return fns(k + 1);
    else if (k == 25)
      return 2 * fns(26);
    else
      return fns(27);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dps_decoder_27_group_sum.sv
// ============================================================================
//  Module   : dps_group_sum_9
//  Brief    : Combinational weighted sum of a 9-bit codeword slice.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dps_group_sum_9
  import dps_decoder_27_pkg::*;
#(
  parameter int unsigned ACC_W = 21,
  parameter int unsigned W0    = 1,
  parameter int unsigned W1    = 1,
  parameter int unsigned W2    = 1,
  parameter int unsigned W3    = 1,
  parameter int unsigned W4    = 1,
  parameter int unsigned W5    = 1,
  parameter int unsigned W6    = 1,
  parameter int unsigned W7    = 1,
  parameter int unsigned W8    = 1
) (
  input  logic [DPS27_GROUP_W-1:0] bits,
  output logic [ACC_W-1:0]         sum
);

  localparam logic [ACC_W-1:0] C_WEIGHT [DPS27_GROUP_W] = '{
    ACC_W'(W0), ACC_W'(W1), ACC_W'(W2), ACC_W'(W3), ACC_W'(W4),
    ACC_W'(W5), ACC_W'(W6), ACC_W'(W7), ACC_W'(W8)
  };

  always_comb begin
    sum = '0;
    for (int i = 0; i < int'(DPS27_GROUP_W); i++) begin
      if (bits[i]) sum = sum + C_WEIGHT[i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/dps_decoder_27.sv
// ============================================================================
//  Module   : dps_decoder_27
//  Brief    : 3-stage DPS Fibonacci CAC decoder (27 wires) with valid/ready.
//             Optional out-of-range check enabled by DPS27_CODE_CHECK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dps_decoder_27
  import dps_decoder_27_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [26:0]        codein,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DBLEN27-1:0] dataout,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef DPS27_CODE_CHECK_EN
  output logic               code_err,
  output logic [CNT_W-1:0]   err_count,
`endif
  output logic [CNT_W-1:0]   word_count
);

  localparam int unsigned ACCW = DPS27_ACCW;
`ifdef DPS27_CODE_CHECK_EN
  localparam int unsigned S_W = ACCW;
`else
  localparam int unsigned S_W = DBLEN27;
`endif

  logic [ACCW-1:0]    grp_sum [DPS27_GROUPS];
  logic [ACCW-1:0]    g_d     [DPS27_GROUPS];
  logic [ACCW-1:0]    g_q     [DPS27_GROUPS];
  logic               v1_d, v1_q;
  logic [S_W-1:0]     s_d, s_q;
  logic               v2_d, v2_q;
  logic [DBLEN27-1:0] dataout_d, dataout_q;
  logic               out_valid_d, out_valid_q;
  logic [CNT_W-1:0]   word_count_d, word_count_q;
  logic               stall;
  logic               deliver;
`ifdef DPS27_CODE_CHECK_EN
  logic               code_err_d, code_err_q;
  logic [CNT_W-1:0]   err_count_d, err_count_q;
`endif

  for (genvar gi = 0; gi < int'(DPS27_GROUPS); gi++) begin : g_group
    dps_group_sum_9 #(
      .ACC_W (ACCW),
      .W0    (dps27_weight(9 * gi + 0)),
      .W1    (dps27_weight(9 * gi + 1)),
      .W2    (dps27_weight(9 * gi + 2)),
      .W3    (dps27_weight(9 * gi + 3)),
      .W4    (dps27_weight(9 * gi + 4)),
      .W5    (dps27_weight(9 * gi + 5)),
      .W6    (dps27_weight(9 * gi + 6)),
      .W7    (dps27_weight(9 * gi + 7)),
      .W8    (dps27_weight(9 * gi + 8))
    ) u_group_sum (
      .bits (codein[9 * gi +: 9]),
      .sum  (grp_sum[gi])
    );
  end

  assign stall   = out_valid_q && !out_ready;
  assign deliver = out_valid_q && out_ready;

  always_comb begin
    g_d          = g_q;
    v1_d         = v1_q;
    s_d          = s_q;
    v2_d         = v2_q;
    dataout_d    = dataout_q;
    out_valid_d  = out_valid_q;
    word_count_d = word_count_q + (deliver ? CNT_W'(1) : CNT_W'(0));
`ifdef DPS27_CODE_CHECK_EN
    code_err_d   = code_err_q;
    err_count_d  = err_count_q;
    if (deliver && code_err_q && (err_count_q != '1))
      err_count_d = err_count_q + CNT_W'(1);
`endif
    // The whole pipe moves as one; a stall freezes every stage.
    if (!stall) begin
      v1_d = in_valid;
      if (in_valid) g_d = grp_sum;
      s_d         = S_W'(g_q[0] + g_q[1] + g_q[2]);
      v2_d        = v1_q;
      dataout_d   = s_q[DBLEN27-1:0];
      out_valid_d = v2_q;
`ifdef DPS27_CODE_CHECK_EN
      code_err_d  = |s_q[ACCW-1:DBLEN27];
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DPS27_GROUPS); i++) g_q[i] <= '0;
      v1_q         <= 1'b0;
      s_q          <= '0;
      v2_q         <= 1'b0;
      dataout_q    <= '0;
      out_valid_q  <= 1'b0;
      word_count_q <= '0;
`ifdef DPS27_CODE_CHECK_EN
      code_err_q   <= 1'b0;
      err_count_q  <= '0;
`endif
    end else begin
      g_q          <= g_d;
      v1_q         <= v1_d;
      s_q          <= s_d;
      v2_q         <= v2_d;
      dataout_q    <= dataout_d;
      out_valid_q  <= out_valid_d;
      word_count_q <= word_count_d;
`ifdef DPS27_CODE_CHECK_EN
      code_err_q   <= code_err_d;
      err_count_q  <= err_count_d;
`endif
    end
  end

  assign in_ready   = !stall;
  assign dataout    = dataout_q;
  assign out_valid  = out_valid_q;
  assign word_count = word_count_q;
`ifdef DPS27_CODE_CHECK_EN
  assign code_err   = code_err_q;
  assign err_count  = err_count_q;
`endif

endmodule

`default_nettype wire
